// File: rtl/trivium_stream.sv
// Purpose : Trivium keystream generator, BPC rounds per clock, packed into OUT_W-bit words.
// Latency : load -> INIT_ROUNDS/BPC warm-up cycles (busy=1) -> first word OUT_W/BPC advances later.
// Backpr. : valid/ready; cipher stalls and ks_data holds while ks_valid=1 and ks_ready=0.
// Ports   : clk, rst_n (async active-low), load/key/iv (rekey strobe), busy (warm-up),
//           ks_data/ks_valid/ks_ready (keystream word handshake).
module trivium_stream #(
  parameter int BPC         = 8,
  parameter int OUT_W       = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic             busy,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready
);

  localparam int N_CHUNK = OUT_W / BPC;
  localparam int N_INIT  = INIT_ROUNDS / BPC;
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int INIT_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);
  localparam logic [INIT_W-1:0]  LAST_INIT  = INIT_W'(N_INIT - 1);

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 ||
          BPC == 16 || BPC == 32 || BPC == 64)) begin : g_bad_bpc
      $error("trivium_stream: BPC must be one of 1,2,4,8,16,32,64");
    end
    if (OUT_W < 1 || OUT_W > 64 || (OUT_W % BPC) != 0) begin : g_bad_out_w
      $error("trivium_stream: OUT_W must be a multiple of BPC and at most 64");
    end
    if (INIT_ROUNDS < 1 || (INIT_ROUNDS % BPC) != 0) begin : g_bad_init
      $error("trivium_stream: INIT_ROUNDS must be a nonzero multiple of BPC");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  // Bit j of s holds Trivium register s(j+1).
  state_t             state;
  logic [287:0]       s;
  logic [287:0]       s_nxt;
  logic [BPC-1:0]     chunk;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   word_nxt;
  logic [CHUNK_W-1:0] chunk_cnt;
  logic [INIT_W-1:0]  init_cnt;
  logic               adv_run;
  logic               word_done;

  function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] st;
    st = '0;
    for (int j = 0; j < 80; j++) begin
      st[j]      = k[79-j];
      st[93 + j] = v[79-j];
    end
    st[287:285] = 3'b111;
    return st;
  endfunction

  // BPC unrolled rounds; round r's z lands at chunk bit BPC-1-r so the
  // earliest keystream bit is the chunk MSB.
  logic [287:0] rs;
  logic         t1, t2, t3;
  always_comb begin
    rs    = s;
    chunk = '0;
    t1    = 1'b0;
    t2    = 1'b0;
    t3    = 1'b0;
    for (int r = 0; r < BPC; r++) begin
      t1 = rs[65]  ^ rs[92];
      t2 = rs[161] ^ rs[176];
      t3 = rs[242] ^ rs[287];
      chunk[BPC-1-r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (rs[90]  & rs[91])  ^ rs[170];
      t2 = t2 ^ (rs[174] & rs[175]) ^ rs[263];
      t3 = t3 ^ (rs[285] & rs[286]) ^ rs[68];
      rs = {rs[286:177], t2, rs[175:93], t1, rs[91:0], t3};
    end
    s_nxt = rs;
  end

  // Older chunks shift toward the MSB; after N_CHUNK advances the stale
  // bits of the previous word have been shifted out entirely.
  assign word_nxt  = (acc << BPC) | OUT_W'(chunk);
  assign adv_run   = (state == RUN) && (!ks_valid || ks_ready);
  assign word_done = (chunk_cnt == LAST_CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      s         <= '0;
      acc       <= '0;
      chunk_cnt <= '0;
      init_cnt  <= '0;
      ks_data   <= '0;
      ks_valid  <= 1'b0;
    end else if (load) begin
      // Rekey wins over any pending transfer on this edge.
      state     <= INIT;
      busy      <= 1'b1;
      s         <= load_state(key, iv);
      acc       <= '0;
      chunk_cnt <= '0;
      init_cnt  <= '0;
      ks_valid  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          s <= s_nxt;
          if (init_cnt == LAST_INIT) begin
            state    <= RUN;
            busy     <= 1'b0;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (adv_run) begin
            s   <= s_nxt;
            acc <= word_nxt;
            if (word_done) begin
              chunk_cnt <= '0;
              ks_data   <= word_nxt;
              ks_valid  <= 1'b1;
            end else begin
              // Either nothing was pending or the pending word was just taken.
              chunk_cnt <= chunk_cnt + 1'b1;
              ks_valid  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_stream.sv
// Purpose : self-checking bench for trivium_stream, three widths in parallel on one key/iv.
// Latency : n/a (bench).
// Backpr. : randomized ks_ready per instance, offered only while expected words remain.
module tb_trivium_stream;

  localparam int NBITS  = 4096;
  localparam int INIT_R = 1152;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [79:0] key;
  logic [79:0] iv;
  logic [2:0]  rdy;

  logic        busy_a, busy_b, busy_c;
  logic        vld_a, vld_b, vld_c;
  logic [7:0]  dat_a;
  logic [15:0] dat_b;
  logic [63:0] dat_c;

  always #5 clk = ~clk;

  trivium_stream #(.BPC(8), .OUT_W(8), .INIT_ROUNDS(INIT_R)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy_a), .ks_data(dat_a), .ks_valid(vld_a), .ks_ready(rdy[0]));

  trivium_stream #(.BPC(8), .OUT_W(16), .INIT_ROUNDS(INIT_R)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy_b), .ks_data(dat_b), .ks_valid(vld_b), .ks_ready(rdy[1]));

  trivium_stream #(.BPC(64), .OUT_W(64), .INIT_ROUNDS(INIT_R)) dut_c (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy_c), .ks_data(dat_c), .ks_valid(vld_c), .ks_ready(rdy[2]));

  logic [2:0]  vld;
  logic [2:0]  bsy;
  logic [63:0] dat [3];
  assign vld    = {vld_c, vld_b, vld_a};
  assign bsy    = {busy_c, busy_b, busy_a};
  assign dat[0] = {56'd0, dat_a};
  assign dat[1] = {48'd0, dat_b};
  assign dat[2] = dat_c;

  int n_tests = 0;
  int n_fail  = 0;
  int xfer [3];

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  bit          ks_bits [$];

  function automatic int wid(input int k);
    case (k)
      0:       return 8;
      1:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push_q(input int k, input logic [63:0] w);
    case (k)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  function automatic logic [63:0] pop_q(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Golden model: bit-serial Trivium on a 1-based register array, one round
  // per iteration; the stream is then cut into words for each instance width.
  task automatic gen_stream(input logic [79:0] k, input logic [79:0] v);
    bit          s [1:288];
    bit          t1, t2, t3, z;
    logic [63:0] w;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[80-i];
      s[93 + i] = v[80-i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    ks_bits.delete();
    q0.delete(); q1.delete(); q2.delete();
    for (int r = 0; r < INIT_R + NBITS; r++) begin
      t1 = s[66]  ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93;  i >= 2;   i--) s[i] = s[i-1];
      for (int i = 177; i >= 95;  i--) s[i] = s[i-1];
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (r >= INIT_R) ks_bits.push_back(z);
    end
    for (int kk = 0; kk < 3; kk++) begin
      for (int i = 0; i < NBITS / wid(kk); i++) begin
        w = '0;
        for (int b = 0; b < wid(kk); b++) w = (w << 1) | 64'(ks_bits[i * wid(kk) + b]);
        push_q(kk, w);
      end
      xfer[kk] = 0;
    end
  endtask

  task automatic set_rdy(input int pct);
    for (int k = 0; k < 3; k++)
      rdy[k] = ($urandom_range(0, 99) < pct) && (qsize(k) > 0);
  endtask

  task automatic tick(input int pct);
    @(posedge clk);
    #1;
    set_rdy(pct);
  endtask

  task automatic do_load(input logic [79:0] k, input logic [79:0] v);
    @(posedge clk);
    #1;
    key  = k;
    iv   = v;
    load = 1'b1;
    gen_stream(k, v);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic chk_xfer_all(input string name);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_words[%0d]", name, k), 64'(xfer[k]), 64'(NBITS / wid(k)));
  endtask

  // Monitor: a word is consumed on the next edge when valid & ready and no
  // load is pending; a stalled word must stay put until taken.
  logic [2:0]  hold_chk = '0;
  logic [63:0] hold_dat [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        hold_chk[k] = 1'b0;
      end else begin
        if (hold_chk[k]) begin
          chk($sformatf("hold_valid[%0d]", k), 64'(vld[k]), 64'd1);
          chk($sformatf("hold_data[%0d]", k), dat[k], hold_dat[k]);
        end
        if (vld[k] && rdy[k] && !load) begin
          if (qsize(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL underflow[%0d]: got word %h, expected no further word", k, dat[k]);
          end else begin
            chk($sformatf("word[%0d]", k), dat[k], pop_q(k));
            xfer[k]++;
          end
        end
        hold_chk[k] = vld[k] && !rdy[k] && !load;
        hold_dat[k] = dat[k];
      end
    end
  end

  initial begin
    int          fall [3];
    int          rise [3];
    int          gap;
    int          bad;
    int          waited;
    logic [63:0] held;

    rst_n = 1'b0;
    load  = 1'b0;
    key   = '0;
    iv    = '0;
    rdy   = '0;
    xfer  = '{0, 0, 0};
    #1;
    chk("reset_busy", 64'(bsy), 64'd0);
    chk("reset_valid", 64'(vld), 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_data[%0d]", k), dat[k], 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick(100);
    chk("idle_no_load", 64'({bsy, vld}), 64'd0);

    // Latency with ready high, on the reference key/iv.
    do_load(80'h9719CFC92A9FF688F9AA, 80'hECBB76B09AFF71D0D151);
    chk("busy_after_load", 64'(bsy), 64'b111);
    fall = '{-1, -1, -1};
    rise = '{-1, -1, -1};
    gap  = 0;
    for (int e = 1; e <= 300; e++) begin
      tick(100);
      for (int k = 0; k < 3; k++) begin
        if (fall[k] < 0 && !bsy[k]) fall[k] = e;
        if (rise[k] < 0 && vld[k])  rise[k] = e;
      end
      if (e > 145 && e <= 200 && !vld[0]) gap++;
    end
    chk("busy_fall_edge[0]", 64'(fall[0]), 64'(INIT_R / 8));
    chk("busy_fall_edge[1]", 64'(fall[1]), 64'(INIT_R / 8));
    chk("busy_fall_edge[2]", 64'(fall[2]), 64'(INIT_R / 64));
    chk("first_valid_edge[0]", 64'(rise[0]), 64'(INIT_R / 8 + 1));
    chk("first_valid_edge[1]", 64'(rise[1]), 64'(INIT_R / 8 + 2));
    chk("first_valid_edge[2]", 64'(rise[2]), 64'(INIT_R / 64 + 1));
    chk("full_rate_gaps", 64'(gap), 64'd0);

    // Equivalence: the full 4096-bit reference stream under random ready.
    repeat (2700) tick(75);
    chk_xfer_all("equiv");

    // Backpressure on the 16-bit instance.
    do_load(rand80(), rand80());
    waited = 0;
    while (!vld[1] && waited < 400) begin
      tick(0);
      waited++;
    end
    chk("bp_valid_seen", 64'(vld[1]), 64'd1);
    held = dat[1];
    repeat (10) tick(0);
    chk("bp_held_valid", 64'(vld[1]), 64'd1);
    chk("bp_held_data", dat[1], held);
    chk("bp_no_xfer", 64'(xfer[1]), 64'd0);
    repeat (800) tick(100);
    chk_xfer_all("bp");

    // Rekey while a word is pending and unaccepted.
    repeat (2) tick(0);
    chk("rekey_pre_valid", 64'(vld[0]), 64'd1);
    do_load(rand80(), rand80());
    chk("rekey_valid_clear", 64'(vld), 64'd0);
    chk("rekey_busy", 64'(bsy), 64'b111);
    repeat (1800) tick(75);
    chk_xfer_all("rekey");

    // Load coinciding with an accepted word: load wins, no transfer.
    do_load(rand80(), rand80());
    repeat (160) tick(100);
    chk("pre_prec_valid", 64'(vld[0] & rdy[0]), 64'd1);
    do_load(rand80(), rand80());
    chk("prec_valid_clear", 64'(vld), 64'd0);

    // Asynchronous reset between edges, mid warm-up.
    repeat (50) tick(100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bsy), 64'd0);
    chk("arst_valid", 64'(vld), 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("arst_data[%0d]", k), dat[k], 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      tick(100);
      rdy = 3'b111;
      if (vld != 3'b000 || bsy != 3'b000) bad++;
    end
    chk("idle_after_arst", 64'(bad), 64'd0);

    // Recovery with a fresh key.
    do_load(rand80(), rand80());
    repeat (1500) tick(60);
    chk_xfer_all("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
